// File: rtl/mux_gate_seq.sv
// mux_gate_seq: bit-serial logic-operation sequencer.
//
// Evaluates AND/OR/NOT/NAND/NOR/XOR/XNOR on two WIDTH-bit operands, LSB
// first, one bit per clock. Every gate is built from one shared 2:1 mux
// (y = sel ? a1 : a0), whose data and select inputs are steered per opcode
// from constants, the current operand-A bit or its inverse, and the operand-B bit.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - command request, sampled only while ready=1
//   opcode - 0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal
//   op_a   - operand A, captured on the accept edge
//   op_b   - operand B, captured on the accept edge (ignored for NOT)
//   ready  - high in IDLE
//   busy   - high in RUN
//   done   - one-cycle pulse when result is valid
//   err    - set by an illegal opcode, held until the next accept
//   result - registered result, held until the next accept
//   zero   - (only with MUX_GATE_SEQ_ZERO_FLAG_EN) final result == 0,
//            updated together with done, 0 for an illegal opcode
//
// Optional feature macro: MUX_GATE_SEQ_ZERO_FLAG_EN

module mux_gate_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
    logic               zero_q, zero_d;
`endif

    // Shared mux input steering
    logic a_bit, s_bit;
    logic m_a0, m_a1, m_sel, mux_y;

    always_comb begin
        a_bit = a_q[0];
        s_bit = b_q[0];
        m_a0  = 1'b0;
        m_a1  = 1'b0;
        m_sel = 1'b0;
        case (op_q)
            OP_AND:  begin m_a0 = 1'b0;   m_a1 = a_bit;  m_sel = s_bit; end
            OP_OR:   begin m_a0 = a_bit;  m_a1 = 1'b1;   m_sel = s_bit; end
            // NOT uses A as the select: a=0 picks 1, a=1 picks 0.
            OP_NOT:  begin m_a0 = 1'b1;   m_a1 = 1'b0;   m_sel = a_bit; end
            OP_NAND: begin m_a0 = 1'b1;   m_a1 = ~a_bit; m_sel = s_bit; end
            OP_NOR:  begin m_a0 = ~a_bit; m_a1 = 1'b0;   m_sel = s_bit; end
            OP_XOR:  begin m_a0 = a_bit;  m_a1 = ~a_bit; m_sel = s_bit; end
            OP_XNOR: begin m_a0 = ~a_bit; m_a1 = a_bit;  m_sel = s_bit; end
            default: begin m_a0 = 1'b0;   m_a1 = 1'b0;   m_sel = 1'b0;  end
        endcase
        mux_y = m_sel ? m_a1 : m_a0;
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    op_d  = opcode;
                    cnt_d = '0;
                    res_d = '0;
                    if (opcode == OP_ILL) begin
                        // Illegal opcode skips RUN and reports immediately.
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
                        zero_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_RUN;
                        err_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = mux_y;
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
                    zero_d  = (res_d == '0);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign err    = err_q;
    assign result = res_q;
`ifdef MUX_GATE_SEQ_ZERO_FLAG_EN
    assign zero   = zero_q;
`endif

endmodule

// File: doc/mux_gate_seq.md
Name: mux_gate_seq

Overview:
- Bit-serial logic-operation sequencer built around one shared 2:1 mux primitive (y = s ? a1 : a0).
- Evaluates one of seven gate functions (AND, OR, NOT, NAND, NOR, XOR, XNOR) on two WIDTH-bit operands, LSB first, one bit per clock.
- Per opcode, it steers constants, the operand bit or its inverse onto the mux data and select inputs.
- Sits between a command source (start/ready handshake) and any consumer of the registered result.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 1 to 64.
- CNT_W, $clog2(WIDTH)+1: bit-counter width; derived, not overridden.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: command request; sampled only when ready=1.
- opcode, input, 3: 0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal.
- op_a, input, WIDTH: operand A; captured on the accept edge.
- op_b, input, WIDTH: operand B; captured on the accept edge; ignored for NOT.
- ready, output, 1: high in IDLE; combinational decode of state.
- busy, output, 1: high in RUN.
- done, output, 1: registered; one-cycle pulse when the result is valid.
- err, output, 1: registered; set by an illegal opcode, held until the next accept.
- result, output, WIDTH: registered result; held stable until the next accept.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - result=0, done=0, err=0, busy=0, ready=1.
  - Internal operand registers and counter cleared.
- States and transitions:
  - IDLE: on start=1, capture op_a, op_b and opcode; clear result and err; cnt=0.
    - Legal opcode: go to RUN.
    - opcode 7: go to DONE with err=1 and result=0.
    - No start: remain in IDLE.
  - RUN: each edge evaluates bit i=cnt with a=A[i], s=B[i] through the shared mux.
    - The result register shifts right and the new bit enters the MSB.
    - The operand registers shift right.
    - cnt increments.
    - When cnt==WIDTH-1, that edge goes to DONE.
  - DONE: lasts exactly one cycle with done=1; the next edge returns to IDLE.
- Per-opcode mux wiring (a0, a1, sel):
  - AND: (0, a, s)
  - OR: (a, 1, s)
  - NOT: (1, 0, a)
  - NAND: (1, ~a, s)
  - NOR: (~a, 0, s)
  - XOR: (a, ~a, s)
  - XNOR: (~a, a, s)
- Latency:
  - Accept edge = edge 0.
  - Legal op: the last bit is written at edge WIDTH; done=1 during the cycle after edge WIDTH; ready returns after edge WIDTH+1.
  - Illegal op: done=1 the cycle after edge 0.
- Boundary conditions:
  - start while busy or in DONE is ignored and not queued.
  - Operand changes after the accept edge have no effect.
  - Back-to-back commands: start may be accepted on the first IDLE edge, so the minimum spacing is WIDTH+2 cycles.
  - WIDTH=1: RUN lasts one edge.
  - rst asserted mid-RUN aborts: no done pulse and result=0.
  - A non-NOT opcode with B held: only the captured values matter.

Optional Feature:
- Macro: MUX_GATE_SEQ_ZERO_FLAG_EN.
- When defined:
  - Adds output port zero (1 bit, registered).
  - zero updates at the same edge as done: 1 if the final result==0, else 0.
  - zero is forced to 0 for an illegal opcode.
  - Reset value 0; held until the next completion.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- AND, A=8'hF0, B=8'h3C, WIDTH=8 -> result=8'h30; done high exactly in the cycle after edge 8; ready=0 for edges 0..8.
- XOR A=8'hA5, B=8'hFF -> 8'h5A; then back-to-back XNOR with the same operands -> 8'hA5; start accepted the first cycle ready=1.
- NOT A=8'h0F, B=8'hAA -> 8'hF0 (B ignored); NAND A=8'hCC, B=8'hAA -> 8'h77; NOR A=8'h0C, B=8'h03 -> 8'hF0.
- opcode=7 -> done the cycle after the accept edge, err=1, result=8'h00; then OR A=8'h01, B=8'h80 -> err=0, result=8'h81.
- Start OR at edge 0; pulse start with new operands at edge 3 -> ignored, result=OR of the first operands. Repeat with rst at edge 3 -> result=0, ready=1, no done pulse.
- With MUX_GATE_SEQ_ZERO_FLAG_EN: NOR A=8'hFF, B=8'h00 -> result 8'h00, zero=1; NAND 8'h00, 8'h00 -> 8'hFF, zero=0.
